// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the shared-ALU connection and the response port of alu_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system (requesters, ALU, consumer).
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [5:0]  req0_func;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [5:0]  req1_func;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [31:0] resp_data;
   logic        resp_zero;
   logic        resp_err;
   logic [7:0]  done_cnt0;
   logic [7:0]  done_cnt1;

   modport slave (
      input  req0_valid, req0_func, req0_a, req0_b,
      input  req1_valid, req1_func, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_ctl, alu_a, alu_b,
      input  alu_out, alu_zero,
      output resp_valid, resp_id, resp_data, resp_zero, resp_err,
      input  resp_ready,
      output done_cnt0, done_cnt1
   );

   modport master (
      output req0_valid, req0_func, req0_a, req0_b,
      output req1_valid, req1_func, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_ctl, alu_a, alu_b,
      output alu_out, alu_zero,
      input  resp_valid, resp_id, resp_data, resp_zero, resp_err,
      output resp_ready,
      input  done_cnt0, done_cnt1
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational MIPS ALU.
// One operation at a time: IDLE (grant) -> EXEC (capture ALU result) -> RESP (hold until consumed).
module alu_arbiter (
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        prio;
   logic        grant_id;
   logic        accept;
   logic        finish;
   logic        ready0;
   logic        ready1;
   logic [5:0]  sel_func;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [3:0]  dec_ctl;
   logic        dec_err;
   logic [3:0]  lat_ctl;
   logic        lat_err;
   logic        lat_id;
   logic [31:0] lat_a;
   logic [31:0] lat_b;
   logic        resp_id_q;
   logic [31:0] resp_data_q;
   logic        resp_zero_q;
   logic        resp_err_q;
   logic [7:0]  cnt0;
   logic [7:0]  cnt1;

   // Unsupported funct codes map to control 15 and raise the error flag.
   always_comb begin
      dec_ctl = 4'd15;
      dec_err = 1'b0;
      case (sel_func)
         6'd32:   dec_ctl = 4'd2;
         6'd34:   dec_ctl = 4'd6;
         6'd36:   dec_ctl = 4'd0;
         6'd37:   dec_ctl = 4'd1;
         6'd39:   dec_ctl = 4'd12;
         6'd42:   dec_ctl = 4'd7;
         default: dec_err = 1'b1;
      endcase
   end

   // A sole valid requester always wins; prio only breaks ties.
   always_comb begin
      grant_id = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;
      sel_func = grant_id ? bus.req1_func : bus.req0_func;
      sel_a    = grant_id ? bus.req1_a    : bus.req0_a;
      sel_b    = grant_id ? bus.req1_b    : bus.req0_b;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      ready0    = 1'b0;
      ready1    = 1'b0;
      case (state)
         IDLE: begin
            if (!reset && (bus.req0_valid || bus.req1_valid)) begin
               accept    = 1'b1;
               ready0    = !grant_id && bus.req0_valid;
               ready1    = grant_id && bus.req1_valid;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (bus.resp_ready) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Reset takes priority, so an operation caught in EXEC/RESP is dropped without counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio        <= 1'b0;
         lat_ctl     <= 4'd0;
         lat_err     <= 1'b0;
         lat_id      <= 1'b0;
         lat_a       <= 32'd0;
         lat_b       <= 32'd0;
         resp_id_q   <= 1'b0;
         resp_data_q <= 32'd0;
         resp_zero_q <= 1'b0;
         resp_err_q  <= 1'b0;
         cnt0        <= 8'd0;
         cnt1        <= 8'd0;
      end else begin
         if (accept) begin
            lat_ctl <= dec_ctl;
            lat_err <= dec_err;
            lat_id  <= grant_id;
            lat_a   <= sel_a;
            lat_b   <= sel_b;
         end
         if (state == EXEC) begin
            resp_id_q   <= lat_id;
            resp_data_q <= bus.alu_out;
            resp_zero_q <= bus.alu_zero;
            resp_err_q  <= lat_err;
         end
         if (finish) begin
            prio <= ~resp_id_q;
            if (resp_id_q) begin
               cnt1 <= cnt1 + 8'd1;
            end else begin
               cnt0 <= cnt0 + 8'd1;
            end
         end
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.alu_ctl    = lat_ctl;
   assign bus.alu_a      = lat_a;
   assign bus.alu_b      = lat_b;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_zero  = resp_zero_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.done_cnt0  = cnt0;
   assign bus.done_cnt1  = cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a standard MIPS ALU model on the shared port, a scoreboard
// filled on every accepted request, and one task per scenario.
module tb_alu_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic        zero;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];
   logic [7:0] exp_cnt0;
   logic [7:0] exp_cnt1;
   logic       model_prio;

   alu_arbiter_if bus();

   alu_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Standard combinational ALU keyed by control code.
   always_comb begin
      case (bus.alu_ctl)
         4'd0:    bus.alu_out = bus.alu_a & bus.alu_b;
         4'd1:    bus.alu_out = bus.alu_a | bus.alu_b;
         4'd2:    bus.alu_out = bus.alu_a + bus.alu_b;
         4'd6:    bus.alu_out = bus.alu_a - bus.alu_b;
         4'd7:    bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
         4'd12:   bus.alu_out = ~(bus.alu_a | bus.alu_b);
         default: bus.alu_out = 32'd0;
      endcase
      bus.alu_zero = (bus.alu_out == 32'd0);
   end

   // Expected response derived straight from the funct code.
   function automatic exp_t exp_of(input logic id, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.id  = id;
      e.err = 1'b0;
      case (f)
         6'd32:   e.data = a + b;
         6'd34:   e.data = a - b;
         6'd36:   e.data = a & b;
         6'd37:   e.data = a | b;
         6'd39:   e.data = ~(a | b);
         6'd42:   e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: begin
            e.data = 32'd0;
            e.err  = 1'b1;
         end
      endcase
      e.zero = (e.data == 32'd0);
      return e;
   endfunction

   function automatic exp_t sb_pop();
      exp_t e;
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      return e;
   endfunction

   // An accept is visible at the negedge before the edge that takes it.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.req0_valid && bus.req0_ready) sb.push_back(exp_of(1'b0, bus.req0_func, bus.req0_a, bus.req0_b));
         if (bus.req1_valid && bus.req1_ready) sb.push_back(exp_of(1'b1, bus.req1_func, bus.req1_a, bus.req1_b));
      end
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      sb.delete();
      exp_cnt0 = 8'd0;
      exp_cnt1 = 8'd0;
      model_prio = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_func = 6'd32; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
      bus.req1_valid = 1'b1; bus.req1_func = 6'd34; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
      bus.resp_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         n_checks++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
         @(posedge clk); #1;
      end
      reset = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      sb.delete();
      exp_cnt0 = 8'd0; exp_cnt1 = 8'd0; model_prio = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid: got %0h expected 0", bus.resp_valid); end
      n_checks++;
      if ({bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== 35'd0) begin n_fail++; $display("[TB] FAIL reset_resp_fields: got %0h expected 0", {bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}); end
      n_checks++;
      if ({bus.alu_ctl, bus.alu_a, bus.alu_b} !== 68'd0) begin n_fail++; $display("[TB] FAIL reset_alu_regs: got %0h expected 0", {bus.alu_ctl, bus.alu_a, bus.alu_b}); end
      n_checks++;
      if ({bus.done_cnt1, bus.done_cnt0} !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_done_cnt: got %0h expected 0", {bus.done_cnt1, bus.done_cnt0}); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_add();
      exp_t e;
      bus.resp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_func = 6'd32; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
      @(negedge clk);
      n_checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL add_ready: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL add_exec_valid: got %0h expected 0", bus.resp_valid); end
      n_checks++;
      if ({bus.alu_ctl, bus.alu_a, bus.alu_b} !== {4'd2, 32'd5, 32'd7}) begin n_fail++; $display("[TB] FAIL add_alu_drive: got %0h expected %0h", {bus.alu_ctl, bus.alu_a, bus.alu_b}, {4'd2, 32'd5, 32'd7}); end
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_resp_latency: got %0h expected 1", bus.resp_valid); end
      e = sb_pop();
      n_checks++;
      if ({bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== {e.id, e.data, e.zero, e.err}) begin n_fail++; $display("[TB] FAIL add_resp: got %0h expected %0h", {bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}, {e.id, e.data, e.zero, e.err}); end
      exp_cnt0 = exp_cnt0 + 8'd1;
      model_prio = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.resp_valid, bus.done_cnt0} !== {1'b0, exp_cnt0}) begin n_fail++; $display("[TB] FAIL add_done: got %0h expected %0h", {bus.resp_valid, bus.done_cnt0}, {1'b0, exp_cnt0}); end
      @(posedge clk); #1;
   endtask

   task automatic test_arbitration();
      exp_t e;
      int   got;
      logic drop0;
      logic drop1;
      logic order_exp [2];
      order_exp = '{1'b0, 1'b1};
      got = 0;
      apply_reset();
      bus.resp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_func = 6'd34; bus.req0_a = 32'd9;    bus.req0_b = 32'd9;
      bus.req1_valid = 1'b1; bus.req1_func = 6'd37; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F;
      for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
         @(negedge clk);
         n_checks++;
         if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_both_ready: got 1 expected 0"); end
         drop0 = bus.req0_ready;
         drop1 = bus.req1_ready;
         if (bus.resp_valid) begin
            e = sb_pop();
            n_checks++;
            if (bus.resp_id !== order_exp[got]) begin n_fail++; $display("[TB] FAIL arb_order: got %0h expected %0h", bus.resp_id, order_exp[got]); end
            n_checks++;
            if ({bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== {e.id, e.data, e.zero, e.err}) begin n_fail++; $display("[TB] FAIL arb_resp: got %0h expected %0h", {bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}, {e.id, e.data, e.zero, e.err}); end
            if (e.id) exp_cnt1 = exp_cnt1 + 8'd1; else exp_cnt0 = exp_cnt0 + 8'd1;
            model_prio = ~e.id;
            got++;
         end
         @(posedge clk); #1;
         if (drop0) bus.req0_valid = 1'b0;
         if (drop1) bus.req1_valid = 1'b0;
      end
      n_checks++;
      if (got !== 2) begin n_fail++; $display("[TB] FAIL arb_timeout: got %0d responses expected 2", got); end
      @(negedge clk);
      n_checks++;
      if ({bus.done_cnt1, bus.done_cnt0} !== {exp_cnt1, exp_cnt0}) begin n_fail++; $display("[TB] FAIL arb_done: got %0h expected %0h", {bus.done_cnt1, bus.done_cnt0}, {exp_cnt1, exp_cnt0}); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      exp_t e;
      bus.resp_ready = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_func = 6'd42; bus.req1_a = 32'd3; bus.req1_b = 32'd4;
      @(negedge clk);
      n_checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_fail++; $display("[TB] FAIL bp_accept: got %b expected 10", {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_func = 6'd36; bus.req0_a = 32'hFF00; bus.req0_b = 32'h0FF0;
      @(negedge clk);
      n_checks++;
      if (bus.req0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_exec_ready: got %0h expected 0", bus.req0_ready); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req1_ready, bus.req0_ready} !== {1'b1, 1'b1, 32'd1, 2'b00}) begin n_fail++; $display("[TB] FAIL bp_hold: got %0h expected %0h", {bus.resp_valid, bus.resp_id, bus.resp_data, bus.req1_ready, bus.req0_ready}, {1'b1, 1'b1, 32'd1, 2'b00}); end
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      e = sb_pop();
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== {1'b1, e.id, e.data, e.zero, e.err}) begin n_fail++; $display("[TB] FAIL bp_resp: got %0h expected %0h", {bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}, {1'b1, e.id, e.data, e.zero, e.err}); end
      exp_cnt1 = exp_cnt1 + 8'd1;
      model_prio = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.req0_ready, bus.done_cnt1} !== {1'b1, exp_cnt1}) begin n_fail++; $display("[TB] FAIL bp_release: got %0h expected %0h", {bus.req0_ready, bus.done_cnt1}, {1'b1, exp_cnt1}); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      e = sb_pop();
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== {1'b1, e.id, e.data, e.zero, e.err}) begin n_fail++; $display("[TB] FAIL bp_pending_resp: got %0h expected %0h", {bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}, {1'b1, e.id, e.data, e.zero, e.err}); end
      exp_cnt0 = exp_cnt0 + 8'd1;
      model_prio = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_bad_funct();
      exp_t e;
      bus.resp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_func = 6'h3F; bus.req0_a = 32'h1234; bus.req0_b = 32'h5678;
      @(negedge clk);
      n_checks++;
      if (bus.req0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_accept: got %0h expected 1", bus.req0_ready); end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.alu_ctl !== 4'd15) begin n_fail++; $display("[TB] FAIL bad_alu_ctl: got %0d expected 15", bus.alu_ctl); end
      @(negedge clk);
      e = sb_pop();
      n_checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== {1'b1, e.id, e.data, e.zero, e.err}) begin n_fail++; $display("[TB] FAIL bad_resp: got %0h expected %0h", {bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}, {1'b1, e.id, e.data, e.zero, e.err}); end
      exp_cnt0 = exp_cnt0 + 8'd1;
      model_prio = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.done_cnt1, bus.done_cnt0} !== {exp_cnt1, exp_cnt0}) begin n_fail++; $display("[TB] FAIL bad_done: got %0h expected %0h", {bus.done_cnt1, bus.done_cnt0}, {exp_cnt1, exp_cnt0}); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_resp();
      apply_reset();
      bus.resp_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_func = 6'd32; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
      @(negedge clk);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_resp_reached: got %0h expected 1", bus.resp_valid); end
      @(posedge clk); #1;
      reset = 1'b1;
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_func = 6'd36; bus.req1_a = 32'd6; bus.req1_b = 32'd3;
      @(negedge clk);
      n_checks++;
      if ({bus.resp_valid, bus.resp_data, bus.done_cnt1, bus.done_cnt0} !== 49'd0) begin n_fail++; $display("[TB] FAIL rst_abort: got %0h expected 0", {bus.resp_valid, bus.resp_data, bus.done_cnt1, bus.done_cnt0}); end
      n_checks++;
      if (bus.req1_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_idle: got %0h expected 1", bus.req1_ready); end
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   p0_acc;
      int   p1_acc;
      int   done_n;
      logic acc0;
      logic acc1;
      logic exp_g;
      logic [5:0] funcs [6];
      funcs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
      apply_reset();
      bus.resp_ready = 1'b1;
      p0_acc = 0; p1_acc = 0; done_n = 0;
      bus.req0_valid = 1'b1; bus.req0_func = 6'd32; bus.req0_a = $urandom(); bus.req0_b = $urandom();
      for (int cyc = 0; cyc < 3000 && done_n < 264; cyc++) begin
         @(negedge clk);
         acc0 = bus.req0_valid & bus.req0_ready;
         acc1 = bus.req1_valid & bus.req1_ready;
         if (bus.req0_ready || bus.req1_ready) begin
            exp_g = (bus.req0_valid && bus.req1_valid) ? model_prio : bus.req1_valid;
            n_checks++;
            if ({bus.req1_ready, bus.req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("[TB] FAIL b2b_grant: got %b expected %b", {bus.req1_ready, bus.req0_ready}, (exp_g ? 2'b10 : 2'b01)); end
         end
         if (bus.resp_valid) begin
            e = sb_pop();
            n_checks++;
            if ({bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err} !== {e.id, e.data, e.zero, e.err}) begin n_fail++; $display("[TB] FAIL b2b_resp: got %0h expected %0h", {bus.resp_id, bus.resp_data, bus.resp_zero, bus.resp_err}, {e.id, e.data, e.zero, e.err}); end
            if (e.id) exp_cnt1 = exp_cnt1 + 8'd1; else exp_cnt0 = exp_cnt0 + 8'd1;
            model_prio = ~e.id;
            done_n++;
         end
         @(posedge clk); #1;
         if (acc0) begin
            p0_acc++;
            if (p0_acc < 256) begin
               bus.req0_a = $urandom(); bus.req0_b = $urandom();
            end else begin
               bus.req0_valid = 1'b0;
            end
         end
         if (acc1) begin
            p1_acc++;
            bus.req1_valid = 1'b0;
         end
         if (!bus.req1_valid && p0_acc >= 40 && p1_acc < 8) begin
            bus.req1_valid = 1'b1;
            bus.req1_func  = funcs[$urandom_range(0, 5)];
            bus.req1_a     = $urandom_range(0, 3);
            bus.req1_b     = $urandom_range(0, 3);
         end
      end
      n_checks++;
      if (done_n !== 264) begin n_fail++; $display("[TB] FAIL b2b_timeout: got %0d responses expected 264", done_n); end
      @(negedge clk);
      n_checks++;
      if ({bus.done_cnt1, bus.done_cnt0} !== {exp_cnt1, exp_cnt0}) begin n_fail++; $display("[TB] FAIL b2b_done_wrap: got %0h expected %0h", {bus.done_cnt1, bus.done_cnt0}, {exp_cnt1, exp_cnt0}); end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_func = 6'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
      bus.req1_valid = 1'b0; bus.req1_func = 6'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
      bus.resp_ready = 1'b0;
      exp_cnt0 = 8'd0; exp_cnt1 = 8'd0; model_prio = 1'b0;
      test_reset();
      test_single_add();
      test_arbitration();
      test_backpressure();
      test_bad_funct();
      test_reset_in_resp();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-004 req0_ready / req1_ready  output  1  requester n's operation accepted this cycle.
REQ-005 req0_func / req1_func  input  6  MIPS R-type funct code.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 alu_ctl  output  4  control code to the shared ALU.
REQ-008 alu_a, alu_b  output  32  operands to the shared ALU.
REQ-009 alu_out  input  32  result from the combinational ALU.
REQ-010 alu_zero  input  1  zero flag from the combinational ALU.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  consumer accepts the response.
REQ-013 resp_id  output  1  requester that owns the response (0/1).
REQ-014 resp_data  output  32  registered ALU result.
REQ-015 resp_zero  output  1  registered zero flag.
REQ-016 resp_err  output  1  funct code was unsupported.
REQ-017 done_cnt0 / done_cnt1  output  8  completed responses per requester.

Function
REQ-018 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-019 IDLE: if any reqN_valid=1, grant one requester, latch its func/a/b and id, then go to EXEC on the next edge; otherwise remain in IDLE.
REQ-020 Arbitration SHALL be round-robin: prio=0 favours port 0, prio=1 favours port 1; a sole valid requester wins regardless of prio.
REQ-021 reqN_ready SHALL be combinational: 1 only in IDLE, only for the granted port, and only when reqN_valid=1; never both high together.
REQ-022 Decode: funct 32->2 (ADD), 34->6 (SUB), 36->0 (AND), 37->1 (OR), 39->12 (NOR), 42->7 (SLT); any other funct->15 with err flag latched.
REQ-023 alu_ctl/alu_a/alu_b SHALL be driven from latched registers only, and stay stable from EXEC through RESP.
REQ-024 EXEC: capture alu_out->resp_data, alu_zero->resp_zero, latched err->resp_err, then go to RESP (one cycle only).
REQ-025 RESP: resp_valid=1; resp_id/data/zero/err SHALL stay stable until resp_ready=1.
REQ-026 On RESP with resp_ready=1: go to IDLE, set prio to the non-served port, increment done_cnt[resp_id].
REQ-027 Latency: acceptance at edge N gives resp_valid=1 after edge N+2; minimum of 3 cycles per operation.
REQ-028 Backpressure: with resp_ready=0, no new request SHALL be accepted.
REQ-029 done_cnt SHALL wrap 255->0 with no saturation.
REQ-030 Simultaneous valid on both ports in IDLE: exactly one SHALL be granted per REQ-020; the loser's request stays pending and is not dropped.
REQ-031 A requester SHALL keep valid/func/a/b stable until it sees ready; the block samples inputs only on the accept cycle.

Reset
REQ-032 reset=1 SHALL force: state=IDLE, prio=0, resp_valid=0, resp_id=0, resp_data=0, resp_zero=0, resp_err=0, done_cnt0=done_cnt1=0, latched func/a/b=0, alu_ctl=0, alu_a=alu_b=0.
REQ-033 reqN_ready SHALL be 0 during any cycle with reset=1.
REQ-034 Reset in EXEC or RESP SHALL abort the operation: no response issued and no counter incremented.

Verification
REQ-035 Port 0 only, funct=32, a=5, b=7, resp_ready=1 -> req0_ready on cycle N, alu_ctl=2, resp_valid at N+2, resp_data=12, resp_zero=0, resp_id=0, done_cnt0=1.
REQ-036 Both ports valid after reset, port0 funct=34 a=9 b=9, port1 funct=37 a=0xF0 b=0x0F -> port 0 first: resp_data=0, resp_zero=1; then port 1: resp_data=0xFF, resp_id=1.
REQ-037 Port 1 funct=42 a=3 b=4 with resp_ready=0 for 5 cycles -> resp_valid held high with resp_data=1 stable, req0_ready=req1_ready=0 throughout; completes on the first resp_ready=1.
REQ-038 Port 0 funct=0x3F -> alu_ctl=15, resp_err=1, resp_data=alu_out (0 from the standard ALU), resp_zero=1.
REQ-039 reset asserted during RESP -> the next cycle shows resp_valid=0, state=IDLE, done counters unchanged at 0.
REQ-040 256 back-to-back port 0 ADDs -> done_cnt0 wraps to 0; port 1 is interleaved whenever both ports are valid.
